// File: rtl/jam_pkg.sv
// jam_pkg: shared widths, state encoding and cost limits for the JAM cost datapath
package jam_pkg;
  localparam int W_IDX_W = 3;
  localparam int J_IDX_W = 3;
  localparam int COST_W = 7;
  localparam logic [COST_W-1:0] MAX_COST = '1;
  typedef enum logic {S_ARB, S_LOCKED} state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotating-priority picker, first req at or above ptr wins (one-hot)
module rr_pick #(
  parameter int N = 2,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);
  logic [2*N-1:0] dbl, back;
  logic [N-1:0] rot, first;
  // rotate so ptr sits at bit 0, isolate lowest set bit, rotate back
  assign dbl = {req, req} >> ptr;
  assign rot = dbl[N-1:0];
  assign first = rot & (~rot + N'(1));
  assign back = {first, first} << ptr;
  assign gnt = back[2*N-1:N];
endmodule

// File: rtl/jam_cost_arb.sv
// jam_cost_arb: round-robin Cost ROM port arbiter with locked bursts
// and a fixed two-cycle response pipeline back to the owning requester.
module jam_cost_arb
  import jam_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int MAX_BURST = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ-1:0]           req_lock,
  input  logic [W_IDX_W*NREQ-1:0]   req_w,
  input  logic [J_IDX_W*NREQ-1:0]   req_j,
  output logic [NREQ-1:0]           gnt,
  output logic [W_IDX_W-1:0]        W,
  output logic [J_IDX_W-1:0]        J,
  input  logic [COST_W-1:0]         Cost,
  output logic [NREQ-1:0]           rsp_valid,
  output logic [COST_W-1:0]         rsp_cost,
  output logic                      busy
);
  localparam int PW = $clog2(NREQ);
  state_t state;
  logic [PW-1:0] rr_ptr, owner, win, sel;
  logic [3:0] burst_cnt, cnt_nxt;
  logic [NREQ-1:0] pick, v1;
  logic hold, start_lock;
  rr_pick #(.N(NREQ), .PW(PW)) u_pick (.req(req), .ptr(rr_ptr), .gnt(pick));
  // a locked owner that still requests keeps the port; otherwise normal rotation
  assign hold = (state == S_LOCKED) && req[owner];
  assign gnt = RST ? '0 : hold ? NREQ'(1) << owner : pick;
  assign busy = state == S_LOCKED;
  assign sel = hold ? owner : win;
  assign cnt_nxt = burst_cnt >= 4'(MAX_BURST) ? burst_cnt : burst_cnt + 4'd1;
  assign start_lock = req_lock[win] && (MAX_BURST > 1);
  always_comb begin
    win = '0;
    for (int i = 0; i < NREQ; i++)
      if (pick[i]) win = PW'(i);
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state <= S_ARB;
      rr_ptr <= '0;
      owner <= '0;
      burst_cnt <= '0;
      W <= '0;
      J <= '0;
      v1 <= '0;
      rsp_valid <= '0;
      rsp_cost <= '0;
    end else begin
      v1 <= gnt;
      rsp_valid <= v1;
      if (|v1) rsp_cost <= Cost;
      if (|gnt) begin
        W <= req_w[W_IDX_W*sel +: W_IDX_W];
        J <= req_j[J_IDX_W*sel +: J_IDX_W];
      end
      if (hold) begin
        burst_cnt <= cnt_nxt;
        if (!req_lock[owner] || cnt_nxt >= 4'(MAX_BURST)) state <= S_ARB;
      end else if (|pick) begin
        owner <= win;
        rr_ptr <= (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
        state <= start_lock ? S_LOCKED : S_ARB;
        if (start_lock) burst_cnt <= 4'd1;
      end else
        state <= S_ARB;
    end
endmodule

// File: tb/tb_jam_cost_arb.sv
// tb_jam_cost_arb: directed + random checks of jam_cost_arb against a transaction-level model
module tb_jam_cost_arb;
  localparam int N = 2;
  localparam int MB = 8;
  logic CLK = 0, RST = 1;
  logic [N-1:0] req = '0, req_lock = '0, gnt, rsp_valid;
  logic [3*N-1:0] req_w = '0, req_j = '0;
  logic [2:0] W, J;
  logic [6:0] cost, rsp_cost;
  logic busy;
  int rom [8][8];
  typedef struct {int due; int idx; int cost;} rsp_t;
  rsp_t q[$];
  int n = 0, fails = 0, cyc = 0;
  int m_locked, m_owner, m_ptr, m_cnt, m_w, m_j;
  int acc, pulses, last_g;

  jam_cost_arb #(.NREQ(N), .MAX_BURST(MB)) dut (
    .CLK(CLK), .RST(RST), .req(req), .req_lock(req_lock), .req_w(req_w), .req_j(req_j),
    .gnt(gnt), .W(W), .J(J), .Cost(cost), .rsp_valid(rsp_valid), .rsp_cost(rsp_cost), .busy(busy));

  always #5 CLK = ~CLK;
  assign cost = 7'(rom[W][J]);

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic int model_pick(input logic [N-1:0] r);
    if (m_locked != 0 && r[m_owner]) return m_owner;
    for (int k = 0; k < N; k++)
      if (r[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic do_reset();
    RST = 1;
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_W", W, 0);
    chk("rst_J", J, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_cost", rsp_cost, 0);
    chk("rst_busy", busy, 0);
    m_locked = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_w = 0; m_j = 0;
    q.delete();
    @(posedge CLK); cyc++;
    @(negedge CLK);
    RST = 0;
  endtask

  task automatic step(input logic [N-1:0] r, input logic [N-1:0] l,
                      input logic [3*N-1:0] w, input logic [3*N-1:0] j);
    int g;
    req = r; req_lock = l; req_w = w; req_j = j;
    #1;
    g = model_pick(r);
    last_g = g;
    chk("gnt", gnt, g < 0 ? 0 : 1 << g);
    chk("busy", busy, m_locked);
    chk("W", W, m_w);
    chk("J", J, m_j);
    if (q.size() > 0 && q[0].due == cyc) begin
      chk("rsp_valid", rsp_valid, 1 << q[0].idx);
      chk("rsp_cost", rsp_cost, q[0].cost);
      void'(q.pop_front());
    end else
      chk("rsp_idle", rsp_valid, 0);
    if (rsp_valid[0]) begin acc += rsp_cost; pulses++; end
    @(posedge CLK);
    if (g >= 0) begin
      m_w = w[3*g +: 3];
      m_j = j[3*g +: 3];
      q.push_back('{cyc + 2, g, rom[m_w][m_j]});
    end
    if (m_locked != 0 && r[m_owner]) begin
      m_cnt = m_cnt < MB ? m_cnt + 1 : m_cnt;
      if (!l[m_owner] || m_cnt >= MB) m_locked = 0;
    end else begin
      m_locked = 0;
      if (g >= 0) begin
        m_owner = g;
        m_ptr = (g + 1) % N;
        if (l[g] && MB > 1) begin m_locked = 1; m_cnt = 1; end
      end
    end
    cyc++;
    @(negedge CLK);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step('0, '0, '0, '0);
  endtask

  initial begin
    int run, first;
    for (int w = 0; w < 8; w++)
      for (int j = 0; j < 8; j++) rom[w][j] = (w * 13 + j * 7 + 5) % 100;
    rom[3][5] = 42;
    do_reset();
    idle(10);
    // single requester (3,5) -> cost 42 two cycles later
    step(2'b01, 2'b00, {3'd0, 3'd3}, {3'd0, 3'd5});
    idle(1);
    chk("single_W", W, 3);
    chk("single_J", J, 5);
    idle(1);
    chk("single_cost", rsp_cost, 42);
    idle(2);
    // alternation from reset
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(2'b11, 2'b00, {3'(i), 3'(7 - i)}, {3'(i + 1), 3'(i + 2)});
      chk("alt_order", last_g, i % 2);
    end
    idle(3);
    // point rr at requester 1, then locked burst of requester 1
    step(2'b01, 2'b00, '0, '0);
    run = 0; first = -1;
    for (int i = 0; i < 10; i++) begin
      step(2'b11, 2'b10, {3'(i), 3'd2}, {3'd4, 3'(i)});
      if (first < 0) begin
        if (last_g == 1) run++;
        else first = last_g;
      end
    end
    chk("burst_len", run, MB);
    chk("after_burst", first, 0);
    idle(3);
    // owner drops after 3 locked transfers
    step(2'b01, 2'b00, '0, '0);
    for (int i = 0; i < 3; i++) step(2'b11, 2'b10, {3'(i + 1), 3'd0}, {3'(6 - i), 3'd1});
    step(2'b01, 2'b00, {3'd0, 3'd7}, {3'd0, 3'd7});
    chk("drop_gnt", last_g, 0);
    idle(1);
    chk("drop_busy", busy, 0);
    idle(3);
    // reset in the middle of a burst
    step(2'b11, 2'b11, '0, {3'd1, 3'd2});
    step(2'b11, 2'b11, '0, {3'd1, 3'd2});
    do_reset();
    idle(3);
    // full permutation fetch by locked requester 0
    acc = 0; pulses = 0;
    for (int k = 0; k < 8; k++) step(2'b01, 2'b01, {3'd0, 3'(7 - k)}, {3'd0, 3'(k)});
    idle(4);
    begin
      int gold = 0;
      for (int k = 0; k < 8; k++) gold += rom[7 - k][k];
      chk("perm_sum", acc, gold);
      chk("perm_pulses", pulses, 8);
    end
    // random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      step(N'($urandom), N'($urandom), (3*N)'($urandom), (3*N)'($urandom));
    end
    idle(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
    $finish;
  end
endmodule

// File: doc/jam_cost_arb.md
Name: jam_cost_arb

Overview:
- Arbitrates the single Cost ROM port (W/J address out, Cost in) among NREQ requesters.
- Typical requesters: a permutation evaluator, a matrix preloader, and a debug reader.
- Round-robin arbitration with optional locked bursts, so one requester can fetch all 8 costs of one assignment back-to-back.
- Registers the ROM address and returns the cost to the owning requester with fixed latency.

Parameters:
- NREQ, 2, number of requesters (2..4).
- MAX_BURST, 8, maximum consecutive locked grants before forced re-arbitration (1..15).

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous reset, active-high.
- req  in  NREQ  per-requester access request.
- req_lock  in  NREQ  request to keep ownership for the next access; only meaningful with req.
- req_w  in  3*NREQ  worker index, requester i at bits [3i+2:3i].
- req_j  in  3*NREQ  job index, same packing as req_w.
- gnt  out  NREQ  one-hot, combinational; req[i]&gnt[i] is a transfer.
- W  out  3  registered ROM worker address.
- J  out  3  registered ROM job address.
- Cost  in  7  ROM data, valid in the same cycle W/J are driven.
- rsp_valid  out  NREQ  one-hot registered response strobe.
- rsp_cost  out  7  registered cost for the rsp_valid owner.
- busy  out  1  high while in S_LOCKED.

Behaviour:
- Reset (async, any time):
  - state=S_ARB, rr_ptr=0, owner=0, burst_cnt=0.
  - W=0, J=0, rsp_valid=0, rsp_cost=0, busy=0, gnt=0.
  - Responses in flight are discarded; no rsp_valid after reset.
- Transfer timing: transfer at cycle t → W/J = granted req_w/req_j at t+1 → rsp_cost=Cost and rsp_valid[owner]=1 at t+2.
- Throughput: one transfer per cycle sustained; latency 2.
- With no transfer, W/J hold their previous value and rsp_valid=0 the cycle after.
- At most one gnt bit high per cycle; gnt=0 when req=0.
- S_ARB:
  - Grant the first req bit at or after rr_ptr, scanning upward modulo NREQ.
  - On transfer: rr_ptr←winner+1 (mod NREQ), owner←winner.
  - If req_lock[winner] and MAX_BURST>1: burst_cnt←1 and go to S_LOCKED.
  - Otherwise stay in S_ARB.
- S_LOCKED:
  - If req[owner]: gnt=owner only, all others blocked; burst_cnt++.
  - Return to S_ARB after the transfer if req_lock[owner]=0, or if burst_cnt reaches MAX_BURST with this transfer.
  - If req[owner]=0: lock released that cycle, and the same-cycle grant uses S_ARB rules with rr_ptr=owner+1. Ownership never idles a cycle.
- busy = (state==S_LOCKED).
- Forced release at MAX_BURST: rr_ptr already points past owner, so other requesters win next. If no others request, owner wins again and may re-lock.
- Simultaneous requests in S_ARB: pure rotating priority; no starvation within NREQ transfers outside bursts.
- req_w/req_j sampled only on transfer; changing them while not granted has no effect.
- burst_cnt is 4 bits and saturates at MAX_BURST; it cannot wrap.

Decomposition:
- Shared package jam_pkg:
  - W_IDX_W=3, J_IDX_W=3, COST_W=7.
  - State encoding S_ARB/S_LOCKED.
  - MAX_COST constant shared with the JAM cost checker.
- Sub-module rr_pick: combinational rotating-priority one-hot picker (req, rr_ptr → grant), reused by future shared-resource arbiters.
- FSM, address registers, and response pipeline stay in jam_cost_arb.

Test Plan:
- Reset, no req:
  - W=J=0, gnt=0, rsp_valid=0 for 10 cycles.
  - Assert RST mid-burst → all outputs 0 next edge; no stale rsp_valid.
- Single requester:
  - req[0]=1 with (w,j)=(3,5) at t, ROM Cost[3][5]=42.
  - W=3, J=5 at t+1; rsp_valid=01, rsp_cost=42 at t+2.
- Both requesting continuously, no lock:
  - gnt alternates 01,10,01,10 starting with 01 after reset.
  - rsp_valid follows the same pattern two cycles later.
- req_lock[1] held with req[1] and req[0] also high, MAX_BURST=8:
  - gnt[1] for exactly 8 consecutive cycles, busy=1 during the burst.
  - Next grant goes to requester 0.
- Owner drops req[1] after 3 locked transfers:
  - Same cycle gnt=01, busy falls.
  - Responses 1,1,1 then 0 arrive in order with correct costs.
- Full permutation fetch:
  - Requester 0 locks, reads (perm[k],k) for k=0..7 of permutation 0..7 under the contest ROM.
  - Summed rsp_cost matches the golden cost.
  - Exactly 8 rsp_valid pulses.
